shadow_stack_unit: RTL and testbench
====================================

# shadow_stack_unit

Owns the architectural shadow stack pointer (ssp) for the backward-edge CFI extension. Supplies ssp to the ALU for SSPRR/SSPINC and commits the ALU's SSPINC result. Executes shadow-stack push and pop-check operations against memory through a single-outstanding load/store port. Reports completion and faults to the scoreboard/exception path.

## Interface
Parameters:
- XLEN, 64, data/address width (matches riscv::XLEN)
- SSP_RESET, '0, ssp value after reset

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- xbcfie_i  in  1  backward-edge CFI enable for current privilege
- ssp_o  out  XLEN  current ssp (feeds ALU ssp_i); 0 when xbcfie_i=0
- alu_ssp_valid_i  in  1  commit strobe for SSPINC result
- alu_ssp_i  in  XLEN  new ssp from ALU ssp_o
- csr_ssp_we_i  in  1  CSR write to ssp
- csr_ssp_wdata_i  in  XLEN  CSR write data
- op_valid_i  in  1  push/pop-check request
- op_ready_o  out  1  unit can accept an op
- op_is_push_i  in  1  1=push, 0=pop-check
- op_data_i  in  XLEN  value to push / value to compare on pop
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request accepted
- mem_we_o  out  1  1=store, 0=load
- mem_addr_o  out  XLEN  access address
- mem_wdata_o  out  XLEN  store data
- mem_rvalid_i  in  1  response (load data or store ack)
- mem_rdata_i  in  XLEN  load data
- mem_err_i  in  1  access error, qualified by mem_rvalid_i
- done_o  out  1  one-cycle completion pulse
- fault_o  out  1  qualified by done_o
- fault_cause_o  out  2  01 mismatch, 10 access error, 11 misaligned; 00 none

## Operation
- W = XLEN/8; all ssp arithmetic modulo 2^XLEN (wrap-around silent, no fault).
- FSM states: IDLE, REQ, RESP, DONE. op_ready_o=1 only in IDLE.
- IDLE: on op_valid_i&op_ready_o latch op_is_push_i, op_data_i; compute addr = push ? ssp-W : ssp.
  - xbcfie_i=0: go DONE, no memory access, fault_o=0, ssp unchanged.
  - addr[log2(W)-1:0]!=0: go DONE, fault cause 11, no memory access.
  - else go REQ.
- REQ: mem_req_o=1, mem_addr_o=addr, mem_we_o=push, mem_wdata_o=latched data; all held stable until mem_gnt_i; on gnt go RESP.
- RESP: wait mem_rvalid_i. mem_err_i=1 -> cause 10. Pop with mem_rdata_i!=latched data -> cause 01. Else success. Go DONE.
- DONE: done_o=1 for exactly one cycle, fault_o/fault_cause_o valid; -> IDLE.
- ssp update on successful op at the RESP->DONE edge: push ssp<=ssp-W, pop ssp<=ssp+W. Any fault: ssp unchanged.
- ssp write priority (same edge): reset > csr_ssp_we_i > FSM success > alu_ssp_valid_i. Lower-priority write dropped.
- alu_ssp_valid_i ignored when xbcfie_i=0. CSR write honoured regardless of xbcfie_i.
- mem_rvalid_i outside RESP ignored.

## Timing
- Reset values: ssp=SSP_RESET, state IDLE, op_ready_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, fault_o=0, fault_cause_o=00.
- All outputs registered or decoded from state; no combinational path from mem_*_i to mem_req_o.
- Minimum latency (gnt same cycle as req, rvalid next cycle): accept cycle 0, REQ cycle 1, RESP cycle 2, done_o cycle 3; next accept cycle 4.
- Local fault or disabled op: accept cycle 0, done_o cycle 1.
- ssp_o reflects a write on the cycle after the write edge.
- Reset mid-op: FSM to IDLE, mem_req_o drops next cycle; late rvalid ignored; no done_o.

## Test plan
- Reset with SSP_RESET=0x8000_0000: ssp_o=0x8000_0000 (xbcfie_i=1), op_ready_o=1, all other outputs 0.
- Push 0xDEAD_BEEF, ssp=0x1000, gnt immediate, rvalid next cycle: mem_addr_o=0xFF8, mem_we_o=1, done_o in cycle 3, fault_o=0, ssp_o=0xFF8.
- Pop-check 0xDEAD_BEEF at ssp=0xFF8, rdata=0xDEAD_BEEF -> ssp=0x1000, no fault; repeat with rdata=0x1234 -> cause 01, ssp stays 0xFF8.
- Push with mem_err_i=1 on rvalid -> cause 10, ssp unchanged; gnt delayed 3 cycles -> address/data held stable.
- ssp=0x1004 push -> cause 11 in cycle 1, mem_req_o never asserted; ssp=0 push -> address 0xFFFF_FFFF_FFFF_FFF8 (wrap).
- Same-cycle csr_ssp_we_i=0x2000 and alu_ssp_valid_i=0x3000 -> ssp=0x2000; alu only with xbcfie_i=0 -> ignored; reset during REQ -> IDLE, no done_o.

Source files
------------

// File: rtl/shadow_stack_unit.sv
// ---------------------------------------------------------------------------
// shadow_stack_unit
//   Owns the architectural shadow stack pointer (ssp) for backward-edge CFI.
//   Feeds ssp to the ALU, commits SSPINC results and CSR writes, and runs
//   shadow-stack push / pop-check operations through a single-outstanding
//   load/store port. Completion and faults are reported with a done pulse.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   xbcfie_i                 backward-edge CFI enable for current privilege
//   ssp_o                    current ssp (0 while disabled)
//   alu_ssp_valid_i/alu_ssp_i   SSPINC commit from the ALU
//   csr_ssp_we_i/csr_ssp_wdata_i CSR write to ssp
//   op_valid_i/op_ready_o/op_is_push_i/op_data_i   push/pop-check request
//   mem_req_o/mem_gnt_i/mem_we_o/mem_addr_o/mem_wdata_o  memory request
//   mem_rvalid_i/mem_rdata_i/mem_err_i                   memory response
//   done_o/fault_o/fault_cause_o  completion pulse and fault report
//     fault_cause_o: 01 mismatch, 10 access error, 11 misaligned, 00 none
// ---------------------------------------------------------------------------
module shadow_stack_unit #(
    parameter int unsigned      XLEN      = 64,
    parameter logic [XLEN-1:0]  SSP_RESET = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            xbcfie_i,
    output logic [XLEN-1:0] ssp_o,
    input  logic            alu_ssp_valid_i,
    input  logic [XLEN-1:0] alu_ssp_i,
    input  logic            csr_ssp_we_i,
    input  logic [XLEN-1:0] csr_ssp_wdata_i,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic            op_is_push_i,
    input  logic [XLEN-1:0] op_data_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    output logic            done_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o
);

    localparam int unsigned     W      = XLEN / 8;
    localparam int unsigned     AW     = $clog2(W);
    localparam logic [XLEN-1:0] W_STEP = XLEN'(W);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

    state_e          state_q;
    logic [XLEN-1:0] ssp_q, ssp_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic            push_q;
    logic            fault_q;
    logic [1:0]      cause_q;
    logic [XLEN-1:0] acc_addr;
    logic            fsm_ok;

    // Push pre-decrements, pop reads at the current top.
    assign acc_addr = op_is_push_i ? (ssp_q - W_STEP) : ssp_q;

    // Successful memory completion, the only case where the FSM moves ssp.
    assign fsm_ok = (state_q == S_RESP) && mem_rvalid_i && !mem_err_i &&
                    (push_q || (mem_rdata_i == data_q));

    // Later assignments win: CSR > FSM success > ALU commit.
    always_comb begin
        ssp_d = ssp_q;
        if (alu_ssp_valid_i && xbcfie_i) ssp_d = alu_ssp_i;
        if (fsm_ok)                      ssp_d = push_q ? (ssp_q - W_STEP) : (ssp_q + W_STEP);
        if (csr_ssp_we_i)                ssp_d = csr_ssp_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ssp_q   <= SSP_RESET;
            addr_q  <= '0;
            data_q  <= '0;
            push_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            ssp_q <= ssp_d;
            case (state_q)
                S_IDLE: begin
                    fault_q <= 1'b0;
                    cause_q <= CAUSE_NONE;
                    if (op_valid_i) begin
                        push_q <= op_is_push_i;
                        data_q <= op_data_i;
                        addr_q <= acc_addr;
                        if (!xbcfie_i) begin
                            // Disabled: complete silently with no access.
                            state_q <= S_DONE;
                        end else if (acc_addr[AW-1:0] != '0) begin
                            fault_q <= 1'b1;
                            cause_q <= CAUSE_MISALIGN;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) state_q <= S_RESP;
                end
                S_RESP: begin
                    if (mem_rvalid_i) begin
                        if (mem_err_i) begin
                            fault_q <= 1'b1;
                            cause_q <= CAUSE_ACCESS;
                        end else if (!push_q && (mem_rdata_i != data_q)) begin
                            fault_q <= 1'b1;
                            cause_q <= CAUSE_MISMATCH;
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the registered state only.
    assign op_ready_o    = (state_q == S_IDLE);
    assign mem_req_o     = (state_q == S_REQ);
    assign mem_we_o      = push_q && (state_q == S_REQ);
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = data_q;
    assign done_o        = (state_q == S_DONE);
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign ssp_o         = xbcfie_i ? ssp_q : '0;

endmodule

// File: tb/tb_shadow_stack_unit.sv
module tb_shadow_stack_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RST_SSP = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            xbcfie;
    logic [63:0]     ssp_o;
    logic            alu_valid;
    logic [63:0]     alu_ssp;
    logic            csr_we;
    logic [63:0]     csr_wdata;
    logic            op_valid;
    logic            op_ready;
    logic            op_is_push;
    logic [63:0]     op_data;
    logic            mem_req;
    logic            mem_gnt;
    logic            mem_we;
    logic [63:0]     mem_addr;
    logic [63:0]     mem_wdata;
    logic            mem_rvalid;
    logic [63:0]     mem_rdata;
    logic            mem_err;
    logic            done;
    logic            fault;
    logic [1:0]      cause;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [63:0] ssp;
        int          cyc;
    } done_exp_t;

    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];

    shadow_stack_unit #(.XLEN(XLEN), .SSP_RESET(RST_SSP)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .xbcfie_i        (xbcfie),
        .ssp_o           (ssp_o),
        .alu_ssp_valid_i (alu_valid),
        .alu_ssp_i       (alu_ssp),
        .csr_ssp_we_i    (csr_we),
        .csr_ssp_wdata_i (csr_wdata),
        .op_valid_i      (op_valid),
        .op_ready_o      (op_ready),
        .op_is_push_i    (op_is_push),
        .op_data_i       (op_data),
        .mem_req_o       (mem_req),
        .mem_gnt_i       (mem_gnt),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rdata_i     (mem_rdata),
        .mem_err_i       (mem_err),
        .done_o          (done),
        .fault_o         (fault),
        .fault_cause_o   (cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory-request monitor: every cycle a request is up it must match the
    // oldest expected access; the entry retires on grant.
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            if (exp_mem.size() == 0) begin
                chk("mem_req_unexpected", 64'(mem_req), 64'd0);
            end else begin
                chk("mem_addr",  mem_addr,       exp_mem[0].addr);
                chk("mem_we",    64'(mem_we),    64'(exp_mem[0].we));
                chk("mem_wdata", mem_wdata,      exp_mem[0].wdata);
                if (mem_gnt) void'(exp_mem.pop_front());
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'd0);
            end else begin
                done_exp_t e;
                e = exp_done.pop_front();
                chk("done_cycle",  64'(cyc),   64'(e.cyc));
                chk("fault",       64'(fault), 64'(e.fault));
                chk("fault_cause", 64'(cause), 64'(e.cause));
                chk("ssp_at_done", ssp_o,      e.ssp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [63:0] v);
        csr_we = 1'b1;
        csr_wdata = v;
        step();
        csr_we = 1'b0;
    endtask

    // Issue one op and play the memory side. Expected access and completion
    // are queued for the monitors.
    task automatic do_op(input bit push, input logic [63:0] d, input bit mem,
                         input logic [63:0] addr, input int gdly, input bit err,
                         input logic [63:0] rdata, input bit efault,
                         input logic [1:0] ecause, input logic [63:0] essp);
        int n;
        mem_exp_t  m;
        done_exp_t e;
        n = 0;
        while (!op_ready && n < 20) begin
            step();
            n++;
        end
        if (!op_ready) chk("op_ready_timeout", 64'(op_ready), 64'd1);
        op_valid   = 1'b1;
        op_is_push = push;
        op_data    = d;
        if (mem) begin
            m.addr = addr; m.we = push; m.wdata = d;
            exp_mem.push_back(m);
        end
        e.fault = efault; e.cause = ecause; e.ssp = essp;
        e.cyc = cyc + (mem ? 3 + gdly : 1);
        exp_done.push_back(e);
        step();
        op_valid = 1'b0;
        if (mem) begin
            repeat (gdly) step();
            mem_gnt = 1'b1;
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_err    = err;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; xbcfie = 1'b1;
        alu_valid = 1'b0; alu_ssp = '0;
        csr_we = 1'b0; csr_wdata = '0;
        op_valid = 1'b0; op_is_push = 1'b0; op_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ssp",       ssp_o,             RST_SSP);
        chk("rst_op_ready",  64'(op_ready),     64'd1);
        chk("rst_mem_req",   64'(mem_req),      64'd0);
        chk("rst_mem_we",    64'(mem_we),       64'd0);
        chk("rst_mem_addr",  mem_addr,          64'd0);
        chk("rst_mem_wdata", mem_wdata,         64'd0);
        chk("rst_done",      64'(done),         64'd0);
        chk("rst_fault",     64'(fault),        64'd0);
        chk("rst_cause",     64'(cause),        64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        csr_write(64'h1000);
        chk("csr_ssp", ssp_o, 64'h1000);

        // push, immediate grant, rvalid next cycle
        do_op(1, 64'hDEAD_BEEF, 1, 64'hFF8, 0, 0, 64'h0, 0, 2'b00, 64'hFF8);
        // pop-check matching
        do_op(0, 64'hDEAD_BEEF, 1, 64'hFF8, 0, 0, 64'hDEAD_BEEF, 0, 2'b00, 64'h1000);
        // push again, then pop-check mismatch
        do_op(1, 64'hDEAD_BEEF, 1, 64'hFF8, 0, 0, 64'h0, 0, 2'b00, 64'hFF8);
        do_op(0, 64'hDEAD_BEEF, 1, 64'hFF8, 0, 0, 64'h1234, 1, 2'b01, 64'hFF8);
        // push with access error and grant delayed 3 cycles
        do_op(1, 64'h55, 1, 64'hFF0, 3, 1, 64'h0, 1, 2'b10, 64'hFF8);
        // misaligned push
        csr_write(64'h1004);
        do_op(1, 64'h66, 0, 64'h0, 0, 0, 64'h0, 1, 2'b11, 64'h1004);
        // wrap-around push from ssp=0
        csr_write(64'h0);
        do_op(1, 64'hA, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h0, 0, 2'b00,
              64'hFFFF_FFFF_FFFF_FFF8);
        // disabled op: no access, no fault, ssp untouched
        xbcfie = 1'b0;
        do_op(1, 64'hB, 0, 64'h0, 0, 0, 64'h0, 0, 2'b00, 64'h0);
        xbcfie = 1'b1;
        #1;
        chk("ssp_after_disabled", ssp_o, 64'hFFFF_FFFF_FFFF_FFF8);

        // CSR beats ALU on the same edge
        csr_we = 1'b1; csr_wdata = 64'h2000;
        alu_valid = 1'b1; alu_ssp = 64'h3000;
        step();
        csr_we = 1'b0; alu_valid = 1'b0;
        chk("csr_over_alu", ssp_o, 64'h2000);
        // ALU ignored while disabled
        xbcfie = 1'b0;
        alu_valid = 1'b1; alu_ssp = 64'h3000;
        step();
        alu_valid = 1'b0;
        xbcfie = 1'b1;
        #1;
        chk("alu_disabled", ssp_o, 64'h2000);
        // ALU commit while enabled
        alu_valid = 1'b1; alu_ssp = 64'h3000;
        step();
        alu_valid = 1'b0;
        chk("alu_commit", ssp_o, 64'h3000);

        // reset while request outstanding
        csr_write(64'h1000);
        begin
            mem_exp_t m;
            m.addr = 64'hFF8; m.we = 1'b1; m.wdata = 64'h77;
            exp_mem.push_back(m);
        end
        op_valid = 1'b1; op_is_push = 1'b1; op_data = 64'h77;
        step();
        op_valid = 1'b0;
        chk("req_before_reset", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_mem.delete();
        chk("reset_mid_req_drop", 64'(mem_req), 64'd0);
        chk("reset_mid_ready",    64'(op_ready), 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 64'h77;
        step();
        mem_rvalid = 1'b0;
        repeat (4) step();
        chk("reset_mid_ssp", ssp_o, RST_SSP);

        chk("mem_queue_drained",  64'(exp_mem.size()),  64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
